// File: rtl/ram_arbiter.sv
// ram_arbiter: shares a single-port RAM of 2^ADDR_W words between a
// read-only instruction-fetch port (f_*) and a load/store data port (d_*).
// Non-pipelined: one request is accepted in IDLE, the RAM is strobed in
// ACCESS, the read word is captured in RESP, and the response pulses on
// the first cycle back in IDLE (3 cycles request to response).
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   f_valid/f_ready      fetch request handshake, f_addr = word address
//   f_rsp_valid/_data/_err  fetch response (valid pulses, data/err hold)
//   d_valid/d_ready      data request handshake, d_we/d_addr/d_wdata payload
//   d_rsp_valid/_data/_err  data response (store returns data 0)
//   ram_en/ram_we/ram_addr/ram_wdata/ram_rdata  RAM side; read data is
//                        valid one cycle after a read strobe
//   dbg_state            current controller state (IDLE=0, ACCESS=1, RESP=2)
//
// Handshake: a request transfers on a cycle where valid && ready. Ready is
// combinational, only high in IDLE (and not during reset) and only for the
// requester that wins arbitration, so at most one ready is high per cycle.
// A requester keeps valid and its payload stable until it sees ready.
//
// Optional feature: define ARB_ROUND_ROBIN_EN to alternate ties between
// the ports; without it, data has fixed priority over fetch.

module ram_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_valid,
  output logic              f_ready,
  input  logic [31:0]       f_addr,
  output logic              f_rsp_valid,
  output logic [DATA_W-1:0] f_rsp_data,
  output logic              f_rsp_err,
  input  logic              d_valid,
  output logic              d_ready,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_rsp_valid,
  output logic [DATA_W-1:0] d_rsp_data,
  output logic              d_rsp_err,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        gnt_q;      // {data, fetch}; 0 = no grant
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic              err_q;
  logic              ram_en_q, ram_we_q;
  logic              f_rsp_valid_q, f_rsp_err_q;
  logic [DATA_W-1:0] f_rsp_data_q;
  logic              d_rsp_valid_q, d_rsp_err_q;
  logic [DATA_W-1:0] d_rsp_data_q;

  logic              idle, tie, pick_f, pick_d, accept;
  logic [31:0]       sel_addr;
  logic              sel_we, sel_in_range;
  logic [DATA_W-1:0] rsp_word;

`ifdef ARB_ROUND_ROBIN_EN
  // 1 = fetch won the most recent tie, so data wins the next one.
  logic rr_q, rr_d;
`endif

  always_comb begin
    idle = (state_q == IDLE) && !rst;
    tie  = f_valid && d_valid;
`ifdef ARB_ROUND_ROBIN_EN
    pick_f = tie ? !rr_q : f_valid;
`else
    pick_f = f_valid && !d_valid;
`endif
    pick_d  = d_valid && !pick_f;
    f_ready = idle && pick_f;
    d_ready = idle && pick_d;
    accept  = f_ready || d_ready;

    sel_addr     = d_ready ? d_addr : f_addr;
    sel_we       = d_ready && d_we;
    // No wrap-around: any bit above the RAM index makes the access an error.
    sel_in_range = (sel_addr[31:ADDR_W] == '0);

    // Stores and errored accesses report a zero word.
    rsp_word = (err_q || we_q) ? '0 : ram_rdata;

    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

`ifdef ARB_ROUND_ROBIN_EN
    // Only contested grants move the pointer.
    rr_d = rr_q;
    if (accept && tie) rr_d = f_ready;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      gnt_q         <= '0;
      addr_q        <= '0;
      we_q          <= 1'b0;
      wdata_q       <= '0;
      err_q         <= 1'b0;
      ram_en_q      <= 1'b0;
      ram_we_q      <= 1'b0;
      f_rsp_valid_q <= 1'b0;
      f_rsp_data_q  <= '0;
      f_rsp_err_q   <= 1'b0;
      d_rsp_valid_q <= 1'b0;
      d_rsp_data_q  <= '0;
      d_rsp_err_q   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_q          <= 1'b1;
`endif
    end else begin
      state_q       <= state_d;
      f_rsp_valid_q <= 1'b0;
      d_rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            gnt_q    <= {d_ready, f_ready};
            addr_q   <= sel_addr[ADDR_W-1:0];
            we_q     <= sel_we;
            wdata_q  <= d_ready ? d_wdata : '0;
            err_q    <= !sel_in_range;
            // The RAM strobe is registered here so it is high exactly
            // during the ACCESS cycle.
            ram_en_q <= sel_in_range;
            ram_we_q <= sel_in_range && sel_we;
          end
        end
        ACCESS: begin
          ram_en_q <= 1'b0;
          ram_we_q <= 1'b0;
        end
        RESP: begin
          if (gnt_q[0]) begin
            f_rsp_valid_q <= 1'b1;
            f_rsp_data_q  <= rsp_word;
            f_rsp_err_q   <= err_q;
          end
          if (gnt_q[1]) begin
            d_rsp_valid_q <= 1'b1;
            d_rsp_data_q  <= rsp_word;
            d_rsp_err_q   <= err_q;
          end
          gnt_q <= '0;
        end
        default: ;
      endcase
`ifdef ARB_ROUND_ROBIN_EN
      rr_q <= rr_d;
`endif
    end
  end

  assign ram_en      = ram_en_q;
  assign ram_we      = ram_we_q;
  assign ram_addr    = addr_q;
  assign ram_wdata   = wdata_q;
  assign f_rsp_valid = f_rsp_valid_q;
  assign f_rsp_data  = f_rsp_data_q;
  assign f_rsp_err   = f_rsp_err_q;
  assign d_rsp_valid = d_rsp_valid_q;
  assign d_rsp_data  = d_rsp_data_q;
  assign d_rsp_err   = d_rsp_err_q;
  assign dbg_state   = state_q;

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
Shares the CPU's single-port 4K-word RAM between two requesters. The instruction-fetch port is read-only. The data port serves lw/sw and can read or write. The block is a non-pipelined 3-state controller: it accepts one request, drives one RAM access, then returns a registered response. It sits between the fetch/execute logic and the RAM array and owns every RAM enable.

Parameters:
- DATA_W, 32, word width of RAM and data buses.
- ADDR_W, 12, RAM word-address width; depth is 2^ADDR_W words.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- f_valid  in  1  fetch request valid.
- f_ready  out  1  fetch request accepted when f_valid & f_ready.
- f_addr  in  32  fetch word address.
- f_rsp_valid  out  1  one-cycle pulse; fetch response present.
- f_rsp_data  out  DATA_W  fetched word.
- f_rsp_err  out  1  fetch address out of range.
- d_valid  in  1  data request valid.
- d_ready  out  1  data request accepted when d_valid & d_ready.
- d_we  in  1  1 = store (sw), 0 = load (lw).
- d_addr  in  32  data word address.
- d_wdata  in  DATA_W  store data.
- d_rsp_valid  out  1  one-cycle pulse; load data or store acknowledge.
- d_rsp_data  out  DATA_W  loaded word; 0 for stores.
- d_rsp_err  out  1  data address out of range.
- ram_en  out  1  RAM access strobe.
- ram_we  out  1  RAM write enable; only valid with ram_en.
- ram_addr  out  ADDR_W  RAM word address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data; valid 1 cycle after ram_en with ram_we = 0.

Behaviour:
- Reset values:
  - All outputs 0; state IDLE; grant register = none; latched request cleared.
  - With ARB_ROUND_ROBIN_EN, rr pointer = fetch (data wins the first tie).
- States and transitions:
  - IDLE -> ACCESS on an accepted handshake.
  - ACCESS -> RESP unconditionally.
  - RESP -> IDLE unconditionally.
- Readiness: f_ready and d_ready are combinational. They are high only in IDLE, and only for the granted requester. At most one ready is high per cycle.
- Arbitration in IDLE (default): data port has fixed priority over fetch. With both valid, d_ready = 1 and f_ready = 0.
- Handshake cycle N (IDLE): latch port id, addr, we and wdata. A requester must hold valid and its payload until accepted.
- Cycle N+1 (ACCESS):
  - In range (addr[31:ADDR_W] == 0): ram_en = 1, ram_we = latched we, ram_addr = addr[ADDR_W-1:0], ram_wdata = latched wdata.
  - Out of range: ram_en = 0 and ram_we = 0. No RAM side effect.
- Cycle N+2 (RESP): capture ram_rdata into the granted port's rsp_data register. Stores capture 0. Errors capture 0 and set the err register.
- Cycle N+3 (back in IDLE):
  - The granted port's rsp_valid is high for exactly one cycle; rsp_err is valid in the same cycle.
  - The other port's rsp_valid stays 0.
  - A new request may be accepted in this same cycle.
- Latency and throughput: request-to-response latency is 3 cycles; one access per 3 cycles. Responses have no backpressure.
- ram_en is never asserted outside ACCESS. Exactly one ram_en pulse per accepted in-range request.
- rsp_data and rsp_err hold their value until the next response on that port. Only rsp_valid pulses.
- Address wrap: addresses are word-granular with no wrap-around. Any upper-bit set is an error, including 0xFFFFFFFF.
- Reset mid-operation (ACCESS or RESP): return to IDLE next cycle, drop the in-flight request with no rsp_valid, and force ram_en/ram_we low from the next cycle. A write already strobed in ACCESS is not rolled back.
- Requests presented while not in IDLE see ready = 0 and are not latched.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- When defined:
  - On a simultaneous f_valid & d_valid in IDLE, grant the port that did not win the previous tie.
  - A 1-bit rr pointer updates only on contested grants.
  - Uncontested grants leave the pointer unchanged.
- When undefined: fixed data-over-fetch priority, and no pointer register exists.

Test Plan:
1. Fetch read: preload ram[0x005] = 0xDEADBEEF; f_valid, f_addr = 5 at cycle 0 -> f_ready = 1 at cycle 0, ram_en = 1 / ram_addr = 5 at cycle 1, f_rsp_valid = 1 with f_rsp_data = 0xDEADBEEF at cycle 3, d_rsp_valid = 0 throughout.
2. Store then load: d_we = 1, d_addr = 0xFFF, d_wdata = 0x12345678 -> ram_we = 1 in ACCESS, d_rsp_valid pulse with d_rsp_data = 0; then a d_we = 0 load of 0xFFF -> d_rsp_data = 0x12345678.
3. Contention (default): f_valid and d_valid held together for 9 cycles -> three data grants, no fetch grant; fetch is accepted in the first IDLE after d_valid drops.
4. Contention (ARB_ROUND_ROBIN_EN): both held continuously -> grants alternate d, f, d, f at cycles 0, 3, 6, 9.
5. Out of range: d_addr = 0x00001000, d_we = 1 -> ram_en stays 0, d_rsp_valid = 1 with d_rsp_err = 1 and d_rsp_data = 0 at cycle 3; RAM contents unchanged.
6. Reset mid-op: assert rst during ACCESS of a fetch read -> no f_rsp_valid ever; state IDLE and f_ready = 1 (f_valid high) in the cycle after rst deasserts.
